enc4b5b_tx_460800: RTL and testbench

ENC4B5B_TX_460800 -- requirements
Module: enc4b5b_tx_460800

---
 rtl/enc4b5b_pkg.sv | 62 ++++++
 rtl/uart_rx_8n1.sv | 100 ++++++++++
 rtl/enc4b5b_tx_460800.sv | 122 ++++++++++++
 tb/tb_enc4b5b_tx_460800.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc4b5b_pkg.sv
// enc4b5b_pkg: shared constants, state codes and
// the 4b5b code table for the PC-to-link bridge.
package enc4b5b_pkg;

  localparam int CLKS_PC_DEF   = 109;
  localparam int CLKS_LINK_DEF = 87;

  localparam logic [7:0] ERR_FRAME = 8'hBB;
  localparam logic [7:0] ERR_OVF   = 8'hAA;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  localparam logic [3:0] TX_LAST_BIT = 4'd11;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } hold_t;

  function automatic logic [4:0] enc5b(
    input logic [3:0] nib
  );
    logic [4:0] c;
    c = 5'b11110;
    unique case (nib)
      4'h0: c = 5'b11110;
      4'h1: c = 5'b01001;
      4'h2: c = 5'b10100;
      4'h3: c = 5'b10101;
      4'h4: c = 5'b01010;
      4'h5: c = 5'b01011;
      4'h6: c = 5'b01110;
      4'h7: c = 5'b01111;
      4'h8: c = 5'b10010;
      4'h9: c = 5'b10011;
      4'hA: c = 5'b10110;
      4'hB: c = 5'b10111;
      4'hC: c = 5'b11010;
      4'hD: c = 5'b11011;
      4'hE: c = 5'b11100;
      4'hF: c = 5'b11101;
    endcase
    return c;
  endfunction

  // bit 0 goes on the wire first
  function automatic logic [11:0] link_frame(
    input logic [7:0] b
  );
    return {1'b1,
            enc5b(b[7:4]),
            enc5b(b[3:0]),
            1'b0};
  endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 receiver for the PC side,
// double-synchronised input, mid-bit sampling.
module uart_rx_8n1
  import enc4b5b_pkg::*;
#(
  parameter int CLKS_PC = CLKS_PC_DEF
) (
  input  logic       CLK_50M,
  input  logic       RESET_N,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int CW =
    (CLKS_PC > 1) ? $clog2(CLKS_PC) : 1;
  localparam logic [CW-1:0] BIT_LAST =
    CW'(CLKS_PC - 1);
  localparam logic [CW-1:0] HALF_LAST =
    CW'(CLKS_PC / 2 - 1);

  logic          rxd_m;
  logic          rxd_s;
  logic          rxd_p;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  assign rx_byte = shreg;

  // two-flop synchroniser plus one delayed copy for edge detect
  always_ff @(posedge CLK_50M) begin
    if (!RESET_N) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
      rxd_p <= 1'b1;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
      rxd_p <= rxd_s;
    end
  end

  // frame FSM: start check at half bit, then whole-bit sampling
  always_ff @(posedge CLK_50M) begin
    if (!RESET_N) begin
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      unique case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rxd_p && !rxd_s)
            state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_LAST) begin
            cnt   <= '0;
            state <= rxd_s ? RX_IDLE
                           : RX_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rxd_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7)
              state <= RX_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt == BIT_LAST) begin
            cnt        <= '0;
            state      <= RX_IDLE;
            byte_valid <= rxd_s;
            frame_err  <= !rxd_s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/enc4b5b_tx_460800.sv
// enc4b5b_tx_460800: PC 8N1 bytes in, 4b5b-coded
// 12-bit link frames out, with LED status.
module enc4b5b_tx_460800
  import enc4b5b_pkg::*;
#(
  parameter int CLKS_PC   = CLKS_PC_DEF,
  parameter int CLKS_LINK = CLKS_LINK_DEF
) (
  input  logic       CLK_50M,
  input  logic       RESET_N,
  input  logic       RS232_DCE_RXD,
  output logic       RS232_DTE_TXD,
  output logic [7:0] LED
);

  localparam int LCW =
    (CLKS_LINK > 1) ? $clog2(CLKS_LINK) : 1;
  localparam logic [LCW-1:0] LINK_LAST =
    LCW'(CLKS_LINK - 1);

  logic [7:0]     rx_byte;
  logic           byte_valid;
  logic           frame_err;

  hold_t          hold;
  logic [0:0]     tx_state;
  logic [LCW-1:0] tx_cnt;
  logic [3:0]     tx_bit;
  logic [10:0]    tx_sh;
  logic           txd_q;
  logic           ovf;
  logic [7:0]     led_q;

  logic           tx_done;
  logic           load;
  logic           push;
  logic           drop;
  logic [11:0]    next_frame;

  uart_rx_8n1 #(
    .CLKS_PC (CLKS_PC)
  ) u_rx (
    .CLK_50M    (CLK_50M),
    .RESET_N    (RESET_N),
    .rxd        (RS232_DCE_RXD),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  assign tx_done = (tx_state == TX_SHIFT)
                && (tx_cnt == LINK_LAST)
                && (tx_bit == TX_LAST_BIT);
  assign load = hold.valid
             && ((tx_state == TX_IDLE)
              || tx_done);
  assign push = byte_valid;
  assign drop = push && hold.valid && !load;
  assign next_frame = link_frame(hold.data);

  assign RS232_DTE_TXD = txd_q;
  assign LED           = led_q;

  // one-entry holding register; a load frees it for a same-cycle push
  always_ff @(posedge CLK_50M) begin
    if (!RESET_N) begin
      hold <= '0;
    end else if (push && !drop) begin
      hold <= '{valid: 1'b1, data: rx_byte};
    end else if (load) begin
      hold.valid <= 1'b0;
    end
  end

  // link shifter: every bit held CLKS_LINK cycles, reload at stop end
  always_ff @(posedge CLK_50M) begin
    if (!RESET_N) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      txd_q    <= 1'b1;
    end else if (load) begin
      tx_state <= TX_SHIFT;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= next_frame[11:1];
      txd_q    <= next_frame[0];
    end else if (tx_state == TX_SHIFT) begin
      if (tx_cnt == LINK_LAST) begin
        tx_cnt <= '0;
        if (tx_bit == TX_LAST_BIT) begin
          tx_state <= TX_IDLE;
          txd_q    <= 1'b1;
        end else begin
          tx_bit <= tx_bit + 1'b1;
          txd_q  <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[10:1]};
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

  // status: overflow is sticky and wins over everything else
  always_ff @(posedge CLK_50M) begin
    if (!RESET_N) begin
      ovf   <= 1'b0;
      led_q <= 8'h00;
    end else begin
      ovf <= ovf | drop;
      if (drop || ovf)
        led_q <= ERR_OVF;
      else if (push)
        led_q <= rx_byte;
      else if (frame_err)
        led_q <= ERR_FRAME;
    end
  end

endmodule

// File: tb/tb_enc4b5b_tx_460800.sv
// tb_enc4b5b_tx_460800: directed + random bytes into
// three configurations, frames checked against a table model.
module tb_enc4b5b_tx_460800;

  localparam int PC   = 109;
  localparam int LK   = 87;
  localparam int LKO  = 200;
  localparam int PCF  = 12;
  localparam int LKF  = 9;

  localparam logic [4:0] CODES [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101,
    5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111,
    5'b11010, 5'b11011, 5'b11100, 5'b11101
  };

  logic       clk;
  logic       rst_n;
  logic       rxd0, rxd1, rxd2;
  logic       txd0, txd1, txd2;
  logic [7:0] led0, led1, led2;

  int total = 0;
  int bad   = 0;
  longint cyc = 0;

  logic [12:0] q0 [$];
  logic [12:0] q1 [$];
  logic [12:0] q2 [$];
  longint      tq1 [$];

  logic [12:0] mf0, mf1, mf2;
  longint      mt0, mt1, mt2;

  enc4b5b_tx_460800 dut (
    .CLK_50M       (clk),
    .RESET_N       (rst_n),
    .RS232_DCE_RXD (rxd0),
    .RS232_DTE_TXD (txd0),
    .LED           (led0)
  );

  enc4b5b_tx_460800 #(
    .CLKS_PC   (PC),
    .CLKS_LINK (LKO)
  ) dut_ovf (
    .CLK_50M       (clk),
    .RESET_N       (rst_n),
    .RS232_DCE_RXD (rxd1),
    .RS232_DTE_TXD (txd1),
    .LED           (led1)
  );

  enc4b5b_tx_460800 #(
    .CLKS_PC   (PCF),
    .CLKS_LINK (LKF)
  ) dut_fast (
    .CLK_50M       (clk),
    .RESET_N       (rst_n),
    .RS232_DCE_RXD (rxd2),
    .RS232_DTE_TXD (txd2),
    .LED           (led2)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] model_frame(
    input logic [7:0] b
  );
    logic [4:0]  lo;
    logic [4:0]  hi;
    logic [11:0] f;
    lo = CODES[b % 16];
    hi = CODES[b / 16];
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      f[1 + i] = lo[i];
      f[6 + i] = hi[i];
    end
    f[11] = 1'b1;
    return f;
  endfunction

  function automatic logic get_txd(input int w);
    case (w)
      0: return txd0;
      1: return txd1;
      default: return txd2;
    endcase
  endfunction

  function automatic int qsize(input int w);
    case (w)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [12:0] pop(input int w);
    logic [12:0] r;
    r = 'x;
    case (w)
      0: if (q0.size() > 0) r = q0.pop_front();
      1: if (q1.size() > 0) r = q1.pop_front();
      default:
        if (q2.size() > 0) r = q2.pop_front();
    endcase
    return r;
  endfunction

  task automatic set_rxd(input int w, input logic v);
    case (w)
      0: rxd0 = v;
      1: rxd1 = v;
      default: rxd2 = v;
    endcase
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // wire-level capture: {clean, bits}, clean = every bit steady
  task automatic mon_frame(
    input  int          w,
    input  int          cl,
    output logic [12:0] r,
    output longint      t
  );
    logic        ok;
    logic [11:0] f;
    ok = 1'b1;
    f  = '0;
    do @(negedge clk); while (get_txd(w) !== 1'b0);
    t = cyc;
    for (int k = 0; k < 12; k++) begin
      for (int j = 0; j < cl; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        if (j == 0) f[k] = get_txd(w);
        else if (get_txd(w) !== f[k]) ok = 1'b0;
      end
    end
    r = {ok, f};
  endtask

  always begin
    mon_frame(0, LK, mf0, mt0);
    q0.push_back(mf0);
  end

  always begin
    mon_frame(1, LKO, mf1, mt1);
    q1.push_back(mf1);
    tq1.push_back(mt1);
  end

  always begin
    mon_frame(2, LKF, mf2, mt2);
    q2.push_back(mf2);
  end

  task automatic send_byte(
    input int         w,
    input logic [7:0] b,
    input logic       stop,
    input int         cl
  );
    set_rxd(w, 1'b0);
    repeat (cl) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rxd(w, b[i]);
      repeat (cl) @(negedge clk);
    end
    set_rxd(w, stop);
    repeat (cl) @(negedge clk);
    set_rxd(w, 1'b1);
  endtask

  task automatic wait_frames(
    input int w,
    input int n,
    input int budget
  );
    for (int i = 0; i < budget && qsize(w) < n; i++)
      @(negedge clk);
    check("wait_frames", qsize(w), n);
  endtask

  task automatic check_frame(
    input int         w,
    input logic [7:0] b,
    input string      tag
  );
    logic [12:0] r;
    r = pop(w);
    check({tag, "_bits"}, {20'd0, r[11:0]},
          {20'd0, model_frame(b)});
    check({tag, "_clean"}, {31'd0, r[12]}, 32'd1);
  endtask

  logic [7:0]  rb [$];
  logic [7:0]  ob [4];
  logic [12:0] r;
  int          zeros;
  int          seen;

  initial begin
    rst_n = 1'b0;
    rxd0  = 1'b1;
    rxd1  = 1'b1;
    rxd2  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_txd", {31'd0, txd0}, 32'd1);
    check("rst_led", {24'd0, led0}, 32'h00);
    check("rst_led_ovf", {24'd0, led1}, 32'h00);
    check("rst_txd_fast", {31'd0, txd2}, 32'd1);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    send_byte(0, 8'hA5, 1'b1, PC);
    wait_frames(0, 1, 2500);
    r = pop(0);
    check("a5_bits", {20'd0, r[11:0]}, 32'hD96);
    check("a5_model", {20'd0, model_frame(8'hA5)},
          32'hD96);
    check("a5_clean", {31'd0, r[12]}, 32'd1);
    check("a5_led", {24'd0, led0}, 32'hA5);

    send_byte(0, 8'h00, 1'b1, PC);
    wait_frames(0, 1, 2500);
    r = pop(0);
    check("x00_bits", {20'd0, r[11:0]}, 32'hFBC);
    check("x00_clean", {31'd0, r[12]}, 32'd1);

    send_byte(0, 8'hFF, 1'b1, PC);
    wait_frames(0, 1, 2500);
    r = pop(0);
    check("xff_bits", {20'd0, r[11:0]}, 32'hF7A);
    check("xff_clean", {31'd0, r[12]}, 32'd1);
    check("xff_led", {24'd0, led0}, 32'hFF);

    send_byte(0, 8'h3C, 1'b0, PC);
    repeat (1500) @(negedge clk);
    check("ferr_noframe", q0.size(), 0);
    check("ferr_led", {24'd0, led0}, 32'hBB);
    send_byte(0, 8'h12, 1'b1, PC);
    wait_frames(0, 1, 2500);
    check_frame(0, 8'h12, "x12");
    check("x12_led", {24'd0, led0}, 32'h12);

    for (int i = 0; i < 8; i++) begin
      rb.push_back(8'($urandom));
      send_byte(0, rb[i], 1'b1, PC);
      repeat ($urandom_range(0, 2) * PC)
        @(negedge clk);
    end
    wait_frames(0, 8, 3000);
    for (int i = 0; i < 8; i++)
      check_frame(0, rb[i], "rnd");
    check("rnd_led", {24'd0, led0},
          {24'd0, rb[7]});

    for (int i = 0; i < 4; i++)
      ob[i] = 8'($urandom);
    fork
      begin
        for (int i = 0; i < 256; i++)
          send_byte(2, 8'(i), 1'b1, PCF);
      end
      begin
        for (int i = 0; i < 3; i++)
          send_byte(1, ob[i], 1'b1, PC);
        wait_frames(1, 2, 4000);
        check("ovf_led", {24'd0, led1}, 32'hAA);
        send_byte(1, ob[3], 1'b1, PC);
        wait_frames(1, 3, 5000);
        repeat (3000) @(negedge clk);
        check("ovf_count", q1.size(), 3);
        check("ovf_b2b", 32'(tq1[1] - tq1[0]),
              12 * LKO);
        check_frame(1, ob[0], "ovf_f0");
        check_frame(1, ob[1], "ovf_f1");
        check_frame(1, ob[3], "ovf_f3");
        check("ovf_sticky", {24'd0, led1},
              32'hAA);
      end
    join
    wait_frames(2, 256, 500);
    for (int i = 0; i < 256; i++)
      check_frame(2, 8'(i), "seq");
    check("seq_led", {24'd0, led2}, 32'hFF);

    send_byte(0, 8'($urandom), 1'b1, PC);
    seen = 0;
    for (int i = 0; i < 3000 && seen == 0; i++) begin
      @(negedge clk);
      if (txd0 === 1'b0) seen = 1;
    end
    check("mid_start", seen, 1);
    repeat (4 * LK + 40) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_txd", {31'd0, txd0}, 32'd1);
    check("mid_rst_led", {24'd0, led0}, 32'h00);
    check("mid_rst_ovf_led", {24'd0, led1}, 32'h00);
    zeros = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (txd0 !== 1'b1) zeros++;
    end
    check("mid_rst_quiet", zeros, 0);
    q0.delete();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
